// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction timer.
//   state_e      : measurement FSM states
//   MaxMsDefault : default saturation limit of the measured time in ms
package reaction_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StTiming,
    StDone,
    StFault
  } state_e;

  localparam int unsigned MaxMsDefault = 9999;

endpackage

// File: rtl/button_sync.sv
// Button synchronizer and rising-edge detector.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   din   : raw button level, asynchronous to clk
//   press : one-clk pulse on a synchronized rising edge
module button_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic press
);

  logic       sync1_q;
  logic       sync2_q;
  logic       prev_q;
  // Fills with ones after reset. An edge is only reported once prev_q holds
  // a real sampled level, so a button held through reset never looks like a press.
  logic [2:0] fill_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      fill_q  <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fill_q  <= {fill_q[1:0], 1'b1};
    end
  end

  assign press = fill_q[2] & sync2_q & ~prev_q;

endmodule

// File: rtl/reaction_timer.sv
// Driver reaction timer: measures ms from lights_out to the first button press.
//   clk, rst   : system clock, asynchronous active-high reset
//   tick       : 1 ms strobe
//   arm        : start of light sequence, restarts a measurement from any state
//   lights_out : all lights extinguished, timing starts
//   button     : raw active-high button, asynchronous
//   time_ms    : measured time (saturates at MAX_MS)
//   valid      : time_ms holds a completed measurement
//   jump_start : press seen before lights_out
//   overflow   : no press within MAX_MS
//   busy       : measurement in progress
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int unsigned N_BIT  = 14,
  parameter int unsigned MAX_MS = MaxMsDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             arm,
  input  logic             lights_out,
  input  logic             button,
  output logic [N_BIT-1:0] time_ms,
  output logic             valid,
  output logic             jump_start,
  output logic             overflow,
  output logic             busy
);

  localparam logic [N_BIT-1:0] LastCnt = N_BIT'(MAX_MS - 1);
  localparam logic [N_BIT-1:0] MaxCnt  = N_BIT'(MAX_MS);

  logic press;

  button_sync u_button_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (button),
    .press (press)
  );

  state_e           state_q, state_d;
  logic [N_BIT-1:0] cnt_q, cnt_d;
  logic [N_BIT-1:0] time_q, time_d;
  logic             valid_q, valid_d;
  logic             jump_q, jump_d;
  logic             ovf_q, ovf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      time_q  <= '0;
      valid_q <= 1'b0;
      jump_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      time_q  <= time_d;
      valid_q <= valid_d;
      jump_q  <= jump_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    time_d  = time_q;
    valid_d = valid_q;
    jump_d  = jump_q;
    ovf_d   = ovf_q;

    // arm overrides everything, including a coincident press
    if (arm) begin
      state_d = StArmed;
      cnt_d   = '0;
      valid_d = 1'b0;
      jump_d  = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        StArmed: begin
          // press beats a coincident lights_out: counts as a jump start
          if (press) begin
            state_d = StFault;
            jump_d  = 1'b1;
          end else if (lights_out) begin
            state_d = StTiming;
            cnt_d   = '0;
          end
        end
        StTiming: begin
          // press beats a coincident tick, so the latched value excludes it
          if (press) begin
            state_d = StDone;
            time_d  = cnt_q;
            valid_d = 1'b1;
          end else if (tick) begin
            if (cnt_q == LastCnt) begin
              state_d = StDone;
              cnt_d   = MaxCnt;
              time_d  = MaxCnt;
              valid_d = 1'b1;
              ovf_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + N_BIT'(1);
            end
          end
        end
        default: ;  // StIdle, StDone, StFault hold until arm
      endcase
    end
  end

  assign time_ms    = time_q;
  assign valid      = valid_q;
  assign jump_start = jump_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q == StArmed) || (state_q == StTiming);

endmodule

// File: tb/tb_reaction_timer.sv
module tb_reaction_timer;

  localparam int unsigned NBit  = 14;
  localparam int unsigned MaxMs = 9999;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            tick = 1'b0;
  logic            arm = 1'b0;
  logic            lights_out = 1'b0;
  logic            button = 1'b0;
  logic [NBit-1:0] time_ms;
  logic            valid;
  logic            jump_start;
  logic            overflow;
  logic            busy;

  reaction_timer #(
    .N_BIT  (NBit),
    .MAX_MS (MaxMs)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .arm        (arm),
    .lights_out (lights_out),
    .button     (button),
    .time_ms    (time_ms),
    .valid      (valid),
    .jump_start (jump_start),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: what the driver would see, in terms of run phases and
  // elapsed milliseconds. Button history is the sequence of levels sampled
  // since reset; a press takes effect three edges after the level rises.
  typedef enum int {PhNone, PhWaitLights, PhRunning, PhResult, PhJumped} phase_e;

  phase_e          m_phase;
  int              m_elapsed;
  logic [NBit-1:0] m_time;
  bit              m_valid, m_jump, m_ovf;
  bit              hist[$];

  function automatic void model_reset();
    m_phase   = PhNone;
    m_elapsed = 0;
    m_time    = '0;
    m_valid   = 0;
    m_jump    = 0;
    m_ovf     = 0;
    hist.delete();
  endfunction

  function automatic void model_edge(input bit a, input bit lo, input bit tk, input bit b);
    bit pr = 0;
    if (hist.size() >= 3) pr = hist[hist.size()-2] && !hist[hist.size()-3];
    hist.push_back(b);
    if (hist.size() > 8) void'(hist.pop_front());

    if (a) begin
      m_phase   = PhWaitLights;
      m_elapsed = 0;
      m_valid   = 0;
      m_jump    = 0;
      m_ovf     = 0;
    end else if (m_phase == PhWaitLights) begin
      if (pr) begin
        m_phase = PhJumped;
        m_jump  = 1;
      end else if (lo) begin
        m_phase   = PhRunning;
        m_elapsed = 0;
      end
    end else if (m_phase == PhRunning) begin
      if (pr) begin
        m_phase = PhResult;
        m_time  = NBit'(m_elapsed);
        m_valid = 1;
      end else if (tk) begin
        m_elapsed++;
        if (m_elapsed >= int'(MaxMs)) begin
          m_phase = PhResult;
          m_time  = NBit'(MaxMs);
          m_valid = 1;
          m_ovf   = 1;
        end
      end
    end
  endfunction

  function automatic logic [31:0] exp_vec();
    bit b = (m_phase == PhWaitLights) || (m_phase == PhRunning);
    return {14'b0, m_time, m_valid, m_jump, m_ovf, b};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {14'b0, time_ms, valid, jump_start, overflow, busy};
  endfunction

  task automatic step(input bit a, input bit lo, input bit tk, input bit b);
    @(negedge clk);
    arm        = a;
    lights_out = lo;
    tick       = tk;
    button     = b;
    @(posedge clk);
    model_edge(a, lo, tk, b);
    #1;
    check("step", dut_vec(), exp_vec());
    check("excl", 32'(valid & jump_start), 32'd0);
  endtask

  task automatic do_reset(input bit b);
    @(negedge clk);
    arm        = 0;
    lights_out = 0;
    tick       = 0;
    button     = b;
    #2 rst = 1;
    #1;
    model_reset();
    check("rst_async", dut_vec(), 32'd0);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic press_seq();
    repeat (3) step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0);
  endtask

  task automatic start_run();
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
  endtask

  bit btn_lvl;

  initial begin
    model_reset();
    do_reset(0);

    // Button held through reset must not register as a press
    do_reset(1);
    repeat (4) step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    repeat (5) step(0, 0, 0, 1);
    check("held_no_jump", 32'(jump_start), 32'd0);
    check("held_busy", 32'(busy), 32'd1);
    repeat (3) step(0, 0, 0, 0);

    // 237 ms measurement
    start_run();
    repeat (237) step(0, 0, 1, 0);
    press_seq();
    check("t237_time", 32'(time_ms), 32'd237);
    check("t237_flags", {28'b0, valid, jump_start, overflow, busy}, 32'b1000);

    // Re-arm from DONE, then 12 ms
    step(1, 0, 0, 0);
    check("rearm_valid", 32'(valid), 32'd0);
    check("rearm_busy", 32'(busy), 32'd1);
    step(0, 1, 0, 0);
    repeat (12) step(0, 0, 1, 0);
    press_seq();
    check("t12_time", 32'(time_ms), 32'd12);
    check("t12_valid", 32'(valid), 32'd1);

    // Jump start, later lights_out ignored
    step(1, 0, 0, 0);
    press_seq();
    check("jump_flags", {28'b0, valid, jump_start, overflow, busy}, 32'b0100);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    check("jump_hold", {28'b0, valid, jump_start, overflow, busy}, 32'b0100);

    // Overflow after MaxMs ticks, later press ignored
    start_run();
    repeat (MaxMs - 1) step(0, 0, 1, 0);
    check("pre_ovf", {28'b0, valid, jump_start, overflow, busy}, 32'b0001);
    step(0, 0, 1, 0);
    check("ovf_time", 32'(time_ms), 32'(MaxMs));
    check("ovf_flags", {28'b0, valid, jump_start, overflow, busy}, 32'b1010);
    press_seq();
    step(0, 0, 1, 0);
    check("ovf_hold", {18'b0, time_ms, valid, overflow}, {18'b0, NBit'(MaxMs), 2'b11});

    // Press coinciding with the 51st tick excludes it
    start_run();
    repeat (50) step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    check("coinc_time", 32'(time_ms), 32'd50);
    repeat (3) step(0, 0, 0, 0);

    // arm coinciding with a press: arm wins
    start_run();
    repeat (5) step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    check("arm_press", {28'b0, valid, jump_start, overflow, busy}, 32'b0001);
    repeat (3) step(0, 0, 0, 0);

    // Reset mid-measurement, then a press before arm is ignored
    start_run();
    repeat (100) step(0, 0, 1, 0);
    do_reset(0);
    check("midrst", dut_vec(), 32'd0);
    press_seq();
    check("post_rst_press", dut_vec(), 32'd0);

    // Randomized traffic against the model
    btn_lvl = 0;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(2999) == 0) begin
        do_reset(btn_lvl);
      end else begin
        if ($urandom_range(14) == 0) btn_lvl = ~btn_lvl;
        step(($urandom_range(299) == 0), ($urandom_range(39) == 0),
             ($urandom_range(1) == 0), btn_lvl);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reaction_timer.md
REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 Parameter N_BIT, default 14: width of time_ms.
REQ-002 Parameter MAX_MS, default 9999: saturation limit of the measured time in ms; must be less than 2^N_BIT.
REQ-003 Port clk, input, 1: single system clock; all flops on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port tick, input, 1: one-clk-wide pulse, one per millisecond, synchronous to clk.
REQ-006 Port arm, input, 1: one-clk pulse from the lights FSM when the light sequence starts.
REQ-007 Port lights_out, input, 1: one-clk pulse from the delay block when all lights extinguish.
REQ-008 Port button, input, 1: raw active-high driver button (already inverted from KEY); asynchronous to clk.
REQ-009 Port time_ms, output, N_BIT: measured reaction time in ms, binary.
REQ-010 Port valid, output, 1: time_ms holds a completed measurement.
REQ-011 Port jump_start, output, 1: button was pressed before lights_out.
REQ-012 Port overflow, output, 1: no press occurred within MAX_MS.
REQ-013 Port busy, output, 1: high in ARMED or TIMING.

Function
REQ-014 button SHALL pass through a 2-flop synchronizer followed by rising-edge detection; only the detected edge (press) is used internally.
REQ-015 A press SHALL be recognised such that its state effect is visible after the 3rd rising clk edge following the raw button rise (setup met).
REQ-016 The FSM SHALL have states IDLE, ARMED, TIMING, DONE, FAULT.
REQ-017 In any state, arm SHALL move to ARMED and clear the counter, valid, jump_start and overflow on the same edge.
REQ-018 In IDLE, press and lights_out SHALL be ignored.
REQ-019 In ARMED, a press SHALL move to FAULT and set jump_start=1; lights_out SHALL move to TIMING with counter=0.
REQ-020 In ARMED, a press and lights_out in the same cycle SHALL count as a jump start (to FAULT).
REQ-021 In TIMING, each tick SHALL increment the counter by 1.
REQ-022 In TIMING, a press SHALL latch the counter into time_ms, set valid=1 and move to DONE.
REQ-023 In TIMING, when a press and a tick coincide, the press SHALL win and the latched value SHALL exclude that tick.
REQ-024 In TIMING, a tick with counter == MAX_MS-1 SHALL set time_ms=MAX_MS, valid=1, overflow=1 and move to DONE; the counter never exceeds MAX_MS.
REQ-025 DONE and FAULT SHALL hold all outputs stable and ignore press, tick and lights_out until arm.
REQ-026 lights_out in TIMING, DONE or FAULT SHALL be ignored.
REQ-027 valid, jump_start and overflow SHALL be registered outputs; at most one of jump_start or valid is high at any time.
REQ-028 arm and a press coinciding SHALL be resolved as arm only; the press is discarded.

Reset
REQ-029 rst high SHALL asynchronously force state=IDLE, counter=0, time_ms=0, valid=0, jump_start=0, overflow=0, busy=0, and clear both synchronizer flops and the edge-detect flop.
REQ-030 After rst deasserts, a button held high SHALL NOT generate a press, because the edge detector starts from a released state only once it has sampled the high level.
REQ-031 rst asserted mid-measurement SHALL discard the measurement; no partial result is presented.

Structure
REQ-032 State encoding and the default MAX_MS constant SHALL live in the shared package reaction_pkg.
REQ-033 Synchronizer plus edge detect SHALL be the sub-module button_sync (ports clk, rst, din, press).
REQ-034 The FSM, counter and output registers SHALL reside in reaction_timer.
REQ-035 The BCD conversion for display is outside this block.

Verification
REQ-036 arm, lights_out, 237 ticks, then press -> valid=1, time_ms=237, jump_start=0, overflow=0, busy=0.
REQ-037 arm, press before lights_out -> jump_start=1, valid=0, state FAULT; a later lights_out leaves the outputs unchanged.
REQ-038 arm, lights_out, no press for 9999 ticks -> valid=1, overflow=1, time_ms=9999; a subsequent press leaves the outputs unchanged.
REQ-039 arm, lights_out, 50 ticks, then a press edge coinciding with the 51st tick -> time_ms=50.
REQ-040 arm, lights_out, 100 ticks, rst pulse -> all outputs 0 and IDLE; a press before the next arm is ignored.
REQ-041 DONE with time_ms=237, then arm -> valid=0 on the same edge, busy=1; a new run of 12 ticks gives time_ms=12.
